wb_bus_arbiter: RTL and testbench

Two-master, four-slave Wishbone arbiter and address decoder for the OpenMIPS SOPC, sitting between the CPU's data port (m0) and instruction port (m1) and the SDRAM, UART, GPIO and flash controllers. It grants the shared bus to one master at a time using round-robin, routes the granted master to the slave selected by address bits [31:28], and returns bus errors for unmapped addresses. It can also return errors for hung slaves when the timeout watchdog is compiled in. It is a lightweight replacement for the general crossbar on this two-master system.

---
 rtl/wb_bus_arbiter.sv | 157 +++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: 2-master/4-slave Wishbone round-robin arbiter and addr[31:28] decoder.
// Define WB_ARB_TIMEOUT_EN to add the hung-slave watchdog (limit TIMEOUT_CYCLES).
module wb_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s0_addr_o,
  output logic [31:0] s0_data_o,
  output logic [3:0]  s0_sel_o,
  output logic        s0_we_o,
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  input  logic [31:0] s0_data_i,
  input  logic        s0_ack_i,
  input  logic        s0_err_i,
  output logic [31:0] s1_addr_o,
  output logic [31:0] s1_data_o,
  output logic [3:0]  s1_sel_o,
  output logic        s1_we_o,
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  input  logic [31:0] s1_data_i,
  input  logic        s1_ack_i,
  input  logic        s1_err_i,
  output logic [31:0] s2_addr_o,
  output logic [31:0] s2_data_o,
  output logic [3:0]  s2_sel_o,
  output logic        s2_we_o,
  output logic        s2_cyc_o,
  output logic        s2_stb_o,
  input  logic [31:0] s2_data_i,
  input  logic        s2_ack_i,
  input  logic        s2_err_i,
  output logic [31:0] s3_addr_o,
  output logic [31:0] s3_data_o,
  output logic [3:0]  s3_sel_o,
  output logic        s3_we_o,
  output logic        s3_cyc_o,
  output logic        s3_stb_o,
  input  logic [31:0] s3_data_i,
  input  logic        s3_ack_i,
  input  logic        s3_err_i
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, uerr_q, uerr_m_q, done_q;
  logic req0, req1, act, gm, gcyc, gstb, gwe, mapped, unmapped, go, fire, done_eff, tout, sack, serr;
  logic [31:0] gaddr, gdata, sdat, err_addr_q;
  logic [3:0] gsel, hit;
  logic [1:0] idx;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign act = state_q != IDLE;
  assign gm = state_q == GNT1;
  assign gaddr = gm ? m1_addr_i : m0_addr_i;
  assign gdata = gm ? m1_data_i : m0_data_i;
  assign gsel = gm ? m1_sel_i : m0_sel_i;
  assign gwe = gm ? m1_we_i : m0_we_i;
  assign gcyc = gm ? m1_cyc_i : m0_cyc_i;
  assign gstb = gm ? m1_stb_i : m0_stb_i;
  assign idx = gaddr[29:28];
  assign mapped = act & (gaddr[31:30] == 2'b00);
  assign unmapped = act & (gaddr[31:30] != 2'b00);
  assign sdat = idx == 2'd0 ? s0_data_i : idx == 2'd1 ? s1_data_i : idx == 2'd2 ? s2_data_i : s3_data_i;
  assign sack = idx == 2'd0 ? s0_ack_i : idx == 2'd1 ? s1_ack_i : idx == 2'd2 ? s2_ack_i : s3_ack_i;
  assign serr = idx == 2'd0 ? s0_err_i : idx == 2'd1 ? s1_err_i : idx == 2'd2 ? s2_err_i : s3_err_i;
  assign go = mapped & gcyc & gstb;
  assign hit = mapped & !tout ? 4'b0001 << idx : 4'b0000;
  assign {s3_addr_o, s2_addr_o, s1_addr_o, s0_addr_o} = {4{act ? gaddr : 32'd0}};
  assign {s3_data_o, s2_data_o, s1_data_o, s0_data_o} = {4{act ? gdata : 32'd0}};
  assign {s3_sel_o, s2_sel_o, s1_sel_o, s0_sel_o} = {4{act ? gsel : 4'd0}};
  assign {s3_we_o, s2_we_o, s1_we_o, s0_we_o} = {4{act & gwe}};
  assign {s3_cyc_o, s2_cyc_o, s1_cyc_o, s0_cyc_o} = hit & {4{gcyc}};
  assign {s3_stb_o, s2_stb_o, s1_stb_o, s0_stb_o} = hit & {4{gstb}};
  assign m0_data_o = mapped & !gm ? sdat : 32'd0;
  assign m1_data_o = mapped & gm ? sdat : 32'd0;
  assign m0_ack_o = go & sack & !gm;
  assign m1_ack_o = go & sack & gm;
  assign m0_err_o = ((go & serr) | tout) & !gm | uerr_q & !uerr_m_q;
  assign m1_err_o = ((go & serr) | tout) & gm | uerr_q & uerr_m_q;
  // An unmapped error fires once per strobe; a new address or master re-arms it.
  assign done_eff = done_q & act & gcyc & gstb & (gaddr == err_addr_q) & (gm == uerr_m_q);
  assign fire = unmapped & gcyc & gstb & !done_eff;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
  logic [15:0] cnt_q;
  logic stall;
  assign stall = go & !sack & !serr;
  assign tout = stall & (cnt_q == TO_LIM);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= stall & !tout ? cnt_q + 16'd1 : 16'd0;
  end
`else
  assign tout = TIMEOUT_CYCLES == 0;
`endif
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (req0 & (!req1 | last_q)) begin
        state_d = GNT0;
        last_d = 1'b0;
      end else if (req1) begin
        state_d = GNT1;
        last_d = 1'b1;
      end
      GNT0: if (!m0_cyc_i) begin
        state_d = req1 ? GNT1 : IDLE;
        last_d = req1 | last_q;
      end
      GNT1: if (!m1_cyc_i) begin
        state_d = req0 ? GNT0 : IDLE;
        last_d = !req0 & last_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      uerr_q <= 1'b0;
      uerr_m_q <= 1'b0;
      done_q <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      uerr_q <= fire;
      done_q <= fire | done_eff;
      if (fire) begin
        uerr_m_q <= gm;
        err_addr_q <= gaddr;
      end
    end
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: randomized + directed check of wb_bus_arbiter against a behavioural ownership model.
module tb_wb_bus_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] m_addr[2], m_wd[2], m_rd[2];
  logic [3:0] m_sel[2];
  logic m_we[2], m_cyc[2], m_stb[2], m_ack[2], m_err[2];
  logic [31:0] s_addr[4], s_wd[4], s_rd[4];
  logic [3:0] s_sel[4];
  logic s_we[4], s_cyc[4], s_stb[4], s_ack[4], s_err[4];
  int n_vec = 0, n_bad = 0;
  int own = -1, last = 1, uerr = -1, dm = 0, cnt = 0;
  bit done = 0, chk_en = 0;
  logic [31:0] da = '0;

  wb_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wd[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_data_o(m_rd[0]), .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wd[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_data_o(m_rd[1]), .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]),
    .s0_addr_o(s_addr[0]), .s0_data_o(s_wd[0]), .s0_sel_o(s_sel[0]), .s0_we_o(s_we[0]), .s0_cyc_o(s_cyc[0]),
    .s0_stb_o(s_stb[0]), .s0_data_i(s_rd[0]), .s0_ack_i(s_ack[0]), .s0_err_i(s_err[0]),
    .s1_addr_o(s_addr[1]), .s1_data_o(s_wd[1]), .s1_sel_o(s_sel[1]), .s1_we_o(s_we[1]), .s1_cyc_o(s_cyc[1]),
    .s1_stb_o(s_stb[1]), .s1_data_i(s_rd[1]), .s1_ack_i(s_ack[1]), .s1_err_i(s_err[1]),
    .s2_addr_o(s_addr[2]), .s2_data_o(s_wd[2]), .s2_sel_o(s_sel[2]), .s2_we_o(s_we[2]), .s2_cyc_o(s_cyc[2]),
    .s2_stb_o(s_stb[2]), .s2_data_i(s_rd[2]), .s2_ack_i(s_ack[2]), .s2_err_i(s_err[2]),
    .s3_addr_o(s_addr[3]), .s3_data_o(s_wd[3]), .s3_sel_o(s_sel[3]), .s3_we_o(s_we[3]), .s3_cyc_o(s_cyc[3]),
    .s3_stb_o(s_stb[3]), .s3_data_i(s_rd[3]), .s3_ack_i(s_ack[3]), .s3_err_i(s_err[3])
  );

  function automatic bit req(int n);
    return m_cyc[n] && m_stb[n];
  endfunction
  function automatic bit mapd(int n);
    return m_addr[n][31:28] < 4'd4;
  endfunction
  function automatic int dec(int n);
    return int'(m_addr[n][29:28]);
  endfunction
  function automatic bit stalled();
    return own >= 0 && req(own) && mapd(own) && !s_ack[dec(own)] && !s_err[dec(own)];
  endfunction
  function automatic bit tout_now();
`ifdef WB_ARB_TIMEOUT_EN
    return stalled() && cnt == TO;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: who owns the bus, who went last, and the pending unmapped-address error.
  always @(posedge clk) begin : model
    bit st, to, same;
    int nerr, prev;
    if (rst) begin
      own = -1; last = 1; uerr = -1; done = 0; cnt = 0;
    end else begin
      st = stalled();
      to = tout_now();
      cnt = (st && !to) ? cnt + 1 : 0;
      same = own >= 0 && done && req(own) && m_addr[own] == da && dm == own;
      nerr = (own >= 0 && req(own) && !mapd(own) && !same) ? own : -1;
      if (nerr >= 0) begin da = m_addr[own]; dm = own; end
      done = same || nerr >= 0;
      uerr = nerr;
      if (own < 0) begin
        if (req(0) && req(1)) own = 1 - last;
        else if (req(0)) own = 0;
        else if (req(1)) own = 1;
        if (own >= 0) last = own;
      end else if (!m_cyc[own]) begin
        prev = own;
        own = req(1 - prev) ? 1 - prev : -1;
        if (own >= 0) last = own;
      end
    end
    chk_en = 1;
  end

  always @(negedge clk) if (chk_en) begin : compare
    bit to, ea, ee, hit;
    logic [31:0] ed;
    to = tout_now();
    for (int n = 0; n < 2; n++) begin
      ed = (own == n && mapd(n)) ? s_rd[dec(n)] : 32'd0;
      ea = own == n && req(n) && mapd(n) && s_ack[dec(n)];
      ee = (own == n && req(n) && mapd(n) && s_err[dec(n)]) || uerr == n || (to && own == n);
      cmp($sformatf("m%0d_out", n), {m_rd[n], m_ack[n], m_err[n]}, {ed, ea, ee});
    end
    for (int k = 0; k < 4; k++) begin
      if (own < 0) cmp($sformatf("s%0d_idle", k), {s_addr[k], s_wd[k], s_sel[k], s_we[k], s_cyc[k], s_stb[k]}, 0);
      else begin
        hit = mapd(own) && dec(own) == k && !to;
        cmp($sformatf("s%0d_out", k), {s_addr[k], s_wd[k], s_sel[k], s_we[k], s_cyc[k], s_stb[k]},
            {m_addr[own], m_wd[own], m_sel[own], m_we[own], hit && m_cyc[own], hit && m_stb[own]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_all();
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0; m_wd[n] = '0; m_sel[n] = '0; m_we[n] = 0; m_cyc[n] = 0; m_stb[n] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      s_rd[k] = '0; s_ack[k] = 0; s_err[k] = 0;
    end
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_all();
    tick();
    tick();
    rst = 0;
    // single master read from s2
    m_addr[0] = 32'h2000_0004; m_sel[0] = 4'hf; m_cyc[0] = 1; m_stb[0] = 1;
    tick();
    tick();
    tick();
    s_ack[2] = 1; s_rd[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    cmp("t1_data", m_rd[0], 32'hDEAD_BEEF);
    cmp("t1_ack", m_ack[0], 1);
    cmp("t1_s2_stb", s_stb[2], 1);
    cmp("t1_other_stb", {s_stb[0], s_stb[1], s_stb[3]}, 0);
    tick();
    idle_all();
    // tie after reset, then direct handover
    do_reset();
    m_addr[0] = 32'h10; m_addr[1] = 32'h20;
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    @(negedge clk);
    cmp("t2_tie_addr", s_addr[0], 32'h10);
    cmp("t2_tie_stb", s_stb[0], 1);
    tick();
    m_cyc[0] = 0; m_stb[0] = 0;
    tick();
    @(negedge clk);
    cmp("t2_handover_addr", s_addr[0], 32'h20);
    cmp("t2_handover_stb", s_stb[0], 1);
    // round robin
    idle_all();
    do_reset();
    m_addr[0] = 32'h100; m_addr[1] = 32'h200; s_ack[0] = 1;
    m_cyc[0] = 1; m_stb[0] = 1; m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmp($sformatf("t3_rr%0d", i), s_addr[0], (i % 2) ? 32'h200 : 32'h100);
      tick();
      m_cyc[i % 2] = 0; m_stb[i % 2] = 0;
      tick();
      m_cyc[i % 2] = 1; m_stb[i % 2] = 1;
    end
    // unmapped access from m1
    idle_all();
    do_reset();
    m_addr[1] = 32'h5000_0000; m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    @(negedge clk);
    cmp("t4_err_grant", m_err[1], 0);
    tick();
    @(negedge clk);
    cmp("t4_err_pulse", m_err[1], 1);
    cmp("t4_no_stb", {s_stb[0], s_stb[1], s_stb[2], s_stb[3]}, 0);
    tick();
    @(negedge clk);
    cmp("t4_err_once", m_err[1], 0);
    // hung slave s3
    idle_all();
    do_reset();
    m_addr[0] = 32'h3000_0000; m_we[0] = 1; m_wd[0] = 32'h1234_5678; m_cyc[0] = 1; m_stb[0] = 1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int j = 0; j < TO; j++) begin
      @(negedge clk);
      cmp($sformatf("t5_wait%0d", j), {m_err[0], s_stb[3]}, 2'b01);
      tick();
    end
    @(negedge clk);
    cmp("t5_timeout", {m_err[0], s_stb[3]}, 2'b10);
    tick();
    @(negedge clk);
    cmp("t5_restart", {m_err[0], s_stb[3]}, 2'b01);
`else
    repeat (20) tick();
    @(negedge clk);
    cmp("t5_stalled", {m_err[0], s_stb[3]}, 2'b01);
`endif
    // reset mid-transfer
    idle_all();
    do_reset();
    m_addr[0] = 32'h40; m_cyc[0] = 1; m_stb[0] = 1;
    tick();
    @(negedge clk);
    cmp("t6_busy", s_stb[0], 1);
    tick();
    rst = 1; s_ack[0] = 1;
    m_addr[1] = 32'h80; m_cyc[1] = 1; m_stb[1] = 1;
    tick();
    rst = 0;
    @(negedge clk);
    cmp("t6_zero", {s_cyc[0], s_stb[0], s_addr[0], m_ack[0], m_err[0], m_rd[0]}, 0);
    tick();
    @(negedge clk);
    cmp("t6_tie_m0", s_addr[0], 32'h40);
    // random traffic
    idle_all();
    do_reset();
    repeat (3000) begin
      for (int n = 0; n < 2; n++) begin
        if (m_cyc[n]) begin
          if ($urandom_range(0, 3) == 0) begin m_cyc[n] = 0; m_stb[n] = 0; end
          else m_stb[n] = $urandom_range(0, 4) != 0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_cyc[n] = 1; m_stb[n] = 1;
          m_addr[n] = {4'($urandom_range(0, 5)), 28'($urandom)};
        end
        if ($urandom_range(0, 7) == 0) m_addr[n] = {4'($urandom_range(0, 5)), 28'($urandom)};
        m_wd[n] = $urandom; m_sel[n] = 4'($urandom); m_we[n] = 1'($urandom);
      end
      for (int k = 0; k < 4; k++) begin
        s_rd[k] = $urandom;
        s_ack[k] = $urandom_range(0, 2) == 0;
        s_err[k] = $urandom_range(0, 15) == 0;
      end
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
